// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load clamp, cascade tc and wrap/load_err pulses.
// Define BCD_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module bcd_updown_counter #(
    parameter int                  DIGITS    = 2,
    parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);

    for (genvar g = 0; g < DIGITS; g++) begin : g_rst_chk
        if (RESET_VAL[4*g +: 4] > 4'd9) begin : g_bad
            $error("RESET_VAL nibble %0d is not a BCD digit", g);
        end
    end

    logic [4*DIGITS-1:0] r_count;
    logic                r_wrap;
    logic                r_load_err;

    logic [DIGITS:0]     w_step;
    logic                w_limit;
    logic [4*DIGITS-1:0] w_cnt_nxt;
    logic [4*DIGITS-1:0] w_load_nxt;
    logic                w_load_bad;

    // w_step[i] is the carry/borrow into digit i; w_step[DIGITS] means all 9s / all 0s
    always_comb begin
        w_step     = '0;
        w_step[0]  = 1'b1;
        w_cnt_nxt  = r_count;
        w_load_nxt = '0;
        w_load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            w_step[i+1] = w_step[i] & (up ? (r_count[4*i +: 4] == 4'd9)
                                          : (r_count[4*i +: 4] == 4'd0));
            if (w_step[i]) begin
                if (up)
                    w_cnt_nxt[4*i +: 4] = (r_count[4*i +: 4] == 4'd9) ? 4'd0
                                        : r_count[4*i +: 4] + 4'd1;
                else
                    w_cnt_nxt[4*i +: 4] = (r_count[4*i +: 4] == 4'd0) ? 4'd9
                                        : r_count[4*i +: 4] - 4'd1;
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                w_load_nxt[4*i +: 4] = 4'd9;
                w_load_bad           = 1'b1;
            end else begin
                w_load_nxt[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    assign w_limit = w_step[DIGITS];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_count    <= RESET_VAL;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            if (load) begin
                r_count    <= w_load_nxt;
                r_load_err <= w_load_bad;
            end else if (en) begin
`ifdef BCD_COUNTER_SAT_EN
                if (!w_limit)
                    r_count <= w_cnt_nxt;
`else
                r_count <= w_cnt_nxt;
                r_wrap  <= w_limit;
`endif
            end
        end
    end

    assign count    = r_count;
    assign tc       = en & ~load & w_limit;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: clear, wrap, borrow, load clamp,
// direction change, two-instance cascade and (if enabled) saturation.
module tb_bcd_updown_counter;

`ifdef BCD_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       clear, en, up, load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc, wrap, load_err;

    logic       c_en, c_load;
    logic [3:0] c_zero;
    logic [3:0] c_lo_cnt, c_hi_cnt;
    logic       c_lo_tc, c_hi_tc;
    logic       c_lo_wrap, c_hi_wrap, c_lo_err, c_hi_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    bcd_updown_counter #(.DIGITS(2)) u_dut (
        .clock(clock), .clear(clear), .en(en), .up(up),
        .load(load), .load_val(load_val), .count(count),
        .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    bcd_updown_counter #(.DIGITS(1)) u_lo (
        .clock(clock), .clear(clear), .en(c_en), .up(up),
        .load(c_load), .load_val(c_zero), .count(c_lo_cnt),
        .tc(c_lo_tc), .wrap(c_lo_wrap), .load_err(c_lo_err)
    );

    bcd_updown_counter #(.DIGITS(1)) u_hi (
        .clock(clock), .clear(clear), .en(c_lo_tc), .up(up),
        .load(c_load), .load_val(c_zero), .count(c_hi_cnt),
        .tc(c_hi_tc), .wrap(c_hi_wrap), .load_err(c_hi_err)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        logic [3:0] e_lo, e_hi;
        clear = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        c_en = 1'b0; c_load = 1'b0; c_zero = '0;
        #1;
        chk("rst_count", count, 8'h00);
        chk("rst_wrap", {7'd0, wrap}, 8'd0);
        chk("rst_err", {7'd0, load_err}, 8'd0);
        tick();
        clear = 1'b0;

        // up wrap 98 -> 99 -> 00 -> 01
        load = 1'b1; load_val = 8'h98;
        tick();
        chk("ld98", count, 8'h98);
        chk("ld98_err", {7'd0, load_err}, 8'd0);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1 chk("tc98", {7'd0, tc}, 8'd0);
        tick();
        chk("up99", count, 8'h99);
        chk("up99_wrap", {7'd0, wrap}, 8'd0);
        chk("tc99", {7'd0, tc}, 8'd1);
        tick();
        chk("up00", count, SAT ? 8'h99 : 8'h00);
        chk("up00_wrap", {7'd0, wrap}, SAT ? 8'd0 : 8'd1);
        chk("tc00", {7'd0, tc}, SAT ? 8'd1 : 8'd0);
        tick();
        chk("up01", count, SAT ? 8'h99 : 8'h01);
        chk("up01_wrap", {7'd0, wrap}, 8'd0);

        // tc gated by load and en
        load = 1'b1; load_val = 8'h99;
        #1 chk("tc_load", {7'd0, tc}, 8'd0);
        tick();
        load = 1'b0;
        #1 chk("tc_en", {7'd0, tc}, 8'd1);
        en = 1'b0;
        #1 chk("tc_noen", {7'd0, tc}, 8'd0);
        tick();
        chk("hold", count, 8'h99);
        chk("hold_wrap", {7'd0, wrap}, 8'd0);

        // down borrow
        load = 1'b1; load_val = 8'h10; en = 1'b1; up = 1'b0;
        tick();
        chk("ld10", count, 8'h10);
        load = 1'b0;
        tick();
        chk("dn09", count, 8'h09);
        tick();
        chk("dn08", count, 8'h08);
        load = 1'b1; load_val = 8'h00;
        tick();
        load = 1'b0;
        #1 chk("tc_dn0", {7'd0, tc}, 8'd1);
        tick();
        chk("dn99", count, SAT ? 8'h00 : 8'h99);
        chk("dn99_wrap", {7'd0, wrap}, SAT ? 8'd0 : 8'd1);
        tick();
        chk("dn98", count, SAT ? 8'h00 : 8'h98);
        chk("dn98_wrap", {7'd0, wrap}, 8'd0);

        // direction change takes effect at the same edge
        load = 1'b1; load_val = 8'h05;
        tick();
        load = 1'b0; up = 1'b1;
        tick();
        chk("dir_up", count, 8'h06);
        up = 1'b0;
        tick();
        chk("dir_dn", count, 8'h05);

        // load clamp and priority over en
        load = 1'b1; load_val = 8'hA5; en = 1'b1; up = 1'b1;
        tick();
        chk("clampA5", count, 8'h95);
        chk("clampA5_err", {7'd0, load_err}, 8'd1);
        load = 1'b0; en = 1'b0;
        tick();
        chk("clamp_hold", count, 8'h95);
        chk("clamp_err_drop", {7'd0, load_err}, 8'd0);
        load = 1'b1; load_val = 8'h3F;
        tick();
        chk("clamp3F", count, 8'h39);
        chk("clamp3F_err", {7'd0, load_err}, 8'd1);
        load_val = 8'hFC;
        tick();
        chk("clampFC", count, 8'h99);
        load_val = 8'h42;
        tick();
        chk("ld42", count, 8'h42);
        chk("ld42_err", {7'd0, load_err}, 8'd0);

        // async clear mid-count
        load_val = 8'h36;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        chk("pre_clr", count, 8'h37);
        #2 clear = 1'b1;
        #1;
        chk("clr_now", count, 8'h00);
        chk("clr_wrap", {7'd0, wrap}, 8'd0);
        chk("clr_err", {7'd0, load_err}, 8'd0);
        tick();
        chk("clr_dom", count, 8'h00);
        clear = 1'b0;
        tick();
        chk("post_clr", count, 8'h01);

        // clear kills a pending load_err pulse
        load = 1'b1; load_val = 8'hA5;
        tick();
        load = 1'b0;
        #2 clear = 1'b1;
        #1 chk("clr_errpulse", {7'd0, load_err}, 8'd0);
        tick();
        clear = 1'b0; en = 1'b0;

        // cascade of two single-digit instances
        up = 1'b1; c_load = 1'b1;
        tick();
        c_load = 1'b0; c_en = 1'b1;
        chk("casc0", {c_hi_cnt, c_lo_cnt}, 8'h00);
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (SAT) begin
                e_lo = (k < 9) ? 4'(k) : 4'd9;
                e_hi = (k <= 9) ? 4'd0 : ((k - 9 > 9) ? 4'd9 : 4'(k - 9));
                chk("casc", {c_hi_cnt, c_lo_cnt}, {e_hi, e_lo});
            end else begin
                chk("casc", {c_hi_cnt, c_lo_cnt}, bcd(k % 100));
            end
        end
        c_en = 1'b0;

`ifdef BCD_COUNTER_SAT_EN
        load = 1'b1; load_val = 8'h99;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("sat99", count, 8'h99);
            chk("sat99_wrap", {7'd0, wrap}, 8'd0);
            chk("sat99_tc", {7'd0, tc}, 8'd1);
        end
        up = 1'b0;
        tick();
        chk("sat98", count, 8'h98);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised multi-digit BCD up/down counter. It generalises our 4-bit decade counter to DIGITS cascaded decades.
- Fully synchronous to one clock, with an asynchronous clear.
- Adds direction control, count enable, parallel load and terminal-count/wrap outputs.
- Used in lab designs as a display-ready event counter. Multiple instances cascade via tc into en.

Parameters:
DIGITS, 2, number of BCD decades; count width is 4*DIGITS bits, range 0 to 10^DIGITS-1.
RESET_VAL, 0, value loaded by clear; each nibble must be 0-9, checked at elaboration.

Ports:
clock  input  1  single clock; all state updates on the rising edge.
clear  input  1  asynchronous reset, active-high.
en  input  1  count enable.
up  input  1  direction: 1 = increment, 0 = decrement.
load  input  1  synchronous parallel load strobe.
load_val  input  4*DIGITS  value to load, nibble i = decade i (nibble 0 = units).
count  output  4*DIGITS  current BCD count, registered.
tc  output  1  combinational terminal count, for cascading.
wrap  output  1  registered one-cycle pulse after a wrap-around.
load_err  output  1  registered one-cycle pulse after a load containing an invalid nibble.

Behaviour:
Clear:
- clear=1 forces, immediately and without waiting for a clock edge: count=RESET_VAL, wrap=0, load_err=0.
- Clear dominates every other input.
- Deassertion takes effect at the next rising edge.

Priority per rising edge: load > en > hold.

Load (load=1):
- count <= load_val, nibble by nibble.
- Any nibble greater than 9 is clamped to 9.
- load_err <= 1 if any nibble was clamped, else 0.
- wrap <= 0.
- en and up are ignored in that cycle.

Up count (load=0, en=1, up=1):
- Digit 0 increments every edge.
- Digit i increments when all lower digits equal 9.
- A digit at 9 that increments becomes 0.
- At all 9s the count becomes 0 and wrap <= 1.

Down count (load=0, en=1, up=0):
- Digit 0 decrements every edge.
- Digit i decrements when all lower digits equal 0.
- A digit at 0 that decrements becomes 9.
- At 0 the count becomes all 9s and wrap <= 1.

Hold (load=0, en=0): count unchanged; wrap <= 0; load_err <= 0.

Pulse clearing: wrap and load_err are 0 in every cycle not listed above. Each is at most 1 cycle wide per event.

tc = en & ~load & ((up & count==all 9s) | (~up & count==0)).
- Purely combinational, no latency.
- Connecting tc to the next instance's en gives correct multi-instance cascading; the same up signal must drive all instances.

Direction change: may occur on any cycle and takes effect at the same edge. There is no extra latency and no lost count.

Latency: count reflects load or enable one edge after it is sampled.

Reset mid-operation: clear during counting or load aborts immediately. The value pending for that edge is discarded.

Widths: no arithmetic wider than 4 bits per digit. count never holds a nibble greater than 9.

Optional Feature:
Macro: BCD_COUNTER_SAT_EN.

Defined (saturating mode):
- Up count holds at all 9s; down count holds at 0.
- wrap stays 0 permanently.
- tc is unchanged, so it still signals the limit and stays asserted while holding.

Undefined: wrap-around behaviour as above.

Test Plan:
1. Clear: DIGITS=2, clear=1 mid-count at 37, no clock edge -> count=00 at once; wrap=0, load_err=0.
2. Up wrap: load 98, en=1, up=1, three edges -> count 99, 00, 01. tc=1 only while count=99. wrap=1 only in the cycle count=00.
3. Down borrow: load 10, up=0, en=1, two edges -> count 09, then 08. Load 00 -> tc=1, next edge gives 99 and wrap=1.
4. Load clamp and priority: load_val=8'hA5, load=1, en=1 -> count=95, load_err=1 for exactly one cycle, no count step that edge.
5. Cascade: two instances (DIGITS=1 each), low.tc driving high.en, 100 up edges from 00 -> combined count returns to 00. High digit steps exactly once per low 9->0 transition.
6. Saturation, with BCD_COUNTER_SAT_EN: at 99 with up=1, five edges -> count stays 99, wrap=0, tc=1. Then up=0, one edge -> 98.
